jk_count_seq: RTL

JK_COUNT_SEQ -- requirements
Module: jk_count_seq

---
 rtl/jk_count_seq_pkg.sv | 14 +
 rtl/jk_cell.sv | 37 +++
 rtl/jk_count_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/jk_count_seq_pkg.sv
// Shared definitions for the JK-flip-flop based up/down counter sequencer.
// Holds the controller state encoding and the direction constants.
package jk_count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic UP = 1'b1;
    localparam logic DN = 1'b0;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with a synchronous active-low clear.
// Hold / set / clear / toggle are selected by the {j,k} pair.
module jk_cell (
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Classic JK next-state table.
    always_comb begin
        q_d = q_q;
        case ({j, k})
            2'b00:   q_d = q_q;
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // Storage flop; the clear overrides any JK drive.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_count_seq.sv
// Counter sequencer: loads or runs a W-bit JK-cell counter up/down toward a
// captured limit, pulsing done for one cycle when the limit is reached.
module jk_count_seq
    import jk_count_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic         dir,
    input  logic [W-1:0] lim,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         abort,
    output logic [W-1:0] q,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic         busy,
    output logic         done
);

    state_e         state_q;
    state_e         state_d;
    logic           dir_q;
    logic           dir_d;
    logic [W-1:0]   lim_q;
    logic [W-1:0]   lim_d;
    logic           busy_q;
    logic           done_q;
    logic [W-1:0]   j_s;
    logic [W-1:0]   k_s;
    logic [W-1:0]   tgl_s;

    // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
    function automatic logic [W-1:0] step_mask(input logic [W-1:0] cur, input logic up);
        logic [W-1:0] m;
        m    = {W{1'b0}};
        m[0] = 1'b1;
        for (int i = 1; i < W; i++) begin
            m[i] = m[i-1] & (up ? cur[i-1] : ~cur[i-1]);
        end
        return m;
    endfunction

    // Toggle mask for the current count and captured direction.
    always_comb begin
        tgl_s = step_mask(q, dir_q == UP);
    end

    // Next-state and JK drive; clear forces every cell to hold.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lim_d   = lim_q;
        j_s     = {W{1'b0}};
        k_s     = {W{1'b0}};
        if (!clr_n) begin
            state_d = IDLE;
            dir_d   = DN;
            lim_d   = {W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        j_s = ld_val;
                        k_s = ~ld_val;
                    end else if (start) begin
                        dir_d   = dir;
                        lim_d   = lim;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_d = IDLE;
                    end else if (q == lim_q) begin
                        state_d = DONE;
                    end else begin
                        j_s = tgl_s;
                        k_s = tgl_s;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Controller registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= IDLE;
            dir_q   <= DN;
            lim_q   <= {W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            lim_q   <= lim_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .clr_n (clr_n),
            .j     (j_s[gi]),
            .k     (k_s[gi]),
            .q     (q[gi])
        );
    end

    assign j    = j_s;
    assign k    = k_s;
    assign busy = busy_q;
    assign done = done_q;

endmodule
